// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
// The instruction-word constants are also provided as macros (NOP_INST, INST_W).
// Optional feature macro: FETCH_BYPASS_EN (see fetch_unit.sv).
`ifndef FETCH_UNIT_CONST_DEFS
`define FETCH_UNIT_CONST_DEFS
`define NOP_INST 32'h00000013
`define INST_W 32
`endif

package fetch_unit_pkg;
  localparam int              INST_W       = `INST_W;
  localparam logic [31:0]     NOP_INST     = `NOP_INST;
  localparam int              DEF_XLEN     = 64;
  localparam logic [63:0]     DEF_RESET_PC = 64'h0000_0000_8000_0000;
  localparam int              DEF_DEPTH    = 2;
endpackage

// File: rtl/fetch_buf.sv
// DEPTH-entry synchronous FIFO of {pc, inst} between memory responses and decode.
// Pointers wrap modulo DEPTH, so non-power-of-two depths are fine.
// Flush wins over push and pop in the same cycle.
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [XLEN-1:0]   push_pc,
  input  logic [INST_W-1:0] push_inst,
  input  logic              pop,
  input  logic              flush,
  output logic [XLEN-1:0]   head_pc,
  output logic [INST_W-1:0] head_inst,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [XLEN-1:0]   pc_mem_q   [DEPTH];
  logic [XLEN-1:0]   pc_mem_d   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_d [DEPTH];
  logic              do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_MAX);
  assign count     = count_q;
  assign head_pc   = pc_mem_q[rd_ptr_q];
  assign head_inst = inst_mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        pc_mem_d[wr_ptr_q]   = push_pc;
        inst_mem_d[wr_ptr_q] = push_inst;
        wr_ptr_d             = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents only matter while count says they are valid.
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues aligned 32-bit fetches,
// buffers returned words with their PCs and hands them to decode.
// Handshakes: a transfer happens on a cycle where valid && ready are both high;
// valid never depends on ready of the same interface, except that decode
// consuming the head frees a credit for a request in that same cycle.
// Optional feature macro: FETCH_BYPASS_EN (response forwarded straight to
// decode when the buffer is empty).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
  parameter int              DEPTH    = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [INST_W-1:0] mem_resp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [INST_W-1:0] dec_inst,
  output logic [XLEN-1:0]   dec_pc
);

  localparam int           CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]  DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0]   pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic              buf_push, buf_pop, buf_full, buf_empty;
  logic [CW-1:0]     buf_count;
  logic [XLEN-1:0]   head_pc;
  logic [INST_W-1:0] head_inst;
  logic              req_fire, resp_drop, resp_keep;
  logic [CW:0]       credit_used;
  logic [XLEN-1:0]   redirect_pc_al;
`ifdef FETCH_BYPASS_EN
  logic              bypass_hit;
`endif

  fetch_buf #(.DEPTH(DEPTH), .XLEN(XLEN)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_pc   (resp_pc_q),
    .push_inst (mem_resp_data),
    .pop       (buf_pop),
    .flush     (redirect_valid),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Response steering, decode outputs and request credits.
  always_comb begin
    redirect_pc_al = redirect_pc & ~XLEN'(3);
    resp_drop      = mem_resp_valid && (drop_cnt_q != '0);
    resp_keep      = rst_n && mem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
    dec_valid      = !buf_empty;
    dec_inst       = buf_empty ? NOP_INST : head_inst;
    dec_pc         = buf_empty ? '0 : head_pc;
    buf_push       = resp_keep;
`ifdef FETCH_BYPASS_EN
    bypass_hit = buf_empty && resp_keep;
    if (bypass_hit) begin
      dec_valid = 1'b1;
      dec_inst  = mem_resp_data;
      dec_pc    = resp_pc_q;
      buf_push  = !dec_ready;
    end
`endif
    // A decode handshake in a redirect cycle is moot: the entry is flushed.
    buf_pop       = !redirect_valid && !buf_empty && dec_ready;
    // The head leaving this cycle frees its slot for a new request, which is
    // what lets DEPTH=2 sustain one instruction per cycle.
    credit_used   = {1'b0, outstanding_q} + {1'b0, buf_count} - (CW + 1)'(buf_pop);
    mem_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_C);
    mem_req_addr  = pc_q;
    req_fire      = mem_req_valid && mem_req_ready;
  end

  // Next-state for fetch PC, response PC, in-flight and drop counters.
  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire);
    // Saturate so a late response to a pre-reset request cannot underflow.
    if (mem_resp_valid && (outstanding_d != '0)) begin
      outstanding_d = outstanding_d - CW'(1);
    end
    if (redirect_valid) begin
      pc_d      = redirect_pc_al;
      resp_pc_d = redirect_pc_al;
      // Everything still in flight is stale; a request accepted last cycle is
      // already counted, and a response arriving now is dropped right here.
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (resp_keep) resp_pc_d = resp_pc_q + XLEN'(4);
      if (resp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Credits must make a push into a full buffer impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(buf_push && buf_full && !buf_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order 1-cycle memory model and a
// PC scoreboard on the decode side.
module tb_fetch_unit;
  localparam int          XLEN  = 64;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mem_req_valid, mem_req_ready = 1'b1;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid = 1'b0;
  logic [31:0]     mem_resp_data = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            dec_valid, dec_ready = 1'b0;
  logic [31:0]     dec_inst;
  logic [XLEN-1:0] dec_pc;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(64'h8000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int n_hs  = 0;
  bit mon_en = 1'b0;
  bit mem_hold = 1'b0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] mem_q[$];

  function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
    return a[31:0] ^ 32'h5EED_0003;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input logic [XLEN-1:0] base);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(base + XLEN'(4 * i));
  endtask

  task automatic do_redirect(input logic [XLEN-1:0] rpc, input logic [XLEN-1:0] first);
    redirect_valid = 1'b1;
    redirect_pc    = rpc;
    load_exp(first);
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_req(input string name, input logic [XLEN-1:0] exp, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        check(name, mem_req_addr, exp);
        seen = 1'b1;
      end
      tick();
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s: got no request want addr %h", name, exp);
    end
  endtask

  // Memory model: in-order, one cycle after acceptance unless held.
  always @(posedge clk) begin
    if (mem_resp_valid) void'(mem_q.pop_front());
    if (mem_req_valid && mem_req_ready) mem_q.push_back(mem_req_addr);
    #2;
    mem_resp_valid = !mem_hold && (mem_q.size() > 0);
    mem_resp_data  = mem_resp_valid ? mem_word(mem_q[0]) : '0;
  end

  // Scoreboard: every decode handshake must match the next expected PC.
  always @(negedge clk) begin
    logic [XLEN-1:0] e;
    if (mon_en && rst_n) begin
      if (dec_valid && dec_ready && !redirect_valid) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL dec_unexpected: got pc %h want none", dec_pc);
        end else begin
          e = exp_q.pop_front();
          check("dec_pc", dec_pc, e);
          check("dec_inst", XLEN'(dec_inst), XLEN'(mem_word(e)));
        end
      end
      if (!dec_valid) begin
        check("idle_inst", XLEN'(dec_inst), XLEN'(NOP));
        check("idle_pc", dec_pc, '0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [XLEN-1:0] rpc;
    logic [XLEN-1:0] a0;
    logic [XLEN-1:0] a1;
  } redir_vec_t;
  redir_vec_t vecs[5];

  initial begin
    int req_cyc, dec_cyc, bubbles, hs0;
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000};
    vecs[1] = '{64'h0000_0000_0000_1003, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_1004};
    vecs[2] = '{64'h0000_0000_0000_0041, 64'h0000_0000_0000_0040, 64'h0000_0000_0000_0044};
    vecs[3] = '{64'h1234_5678_9ABC_DEF2, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF4};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000};

    // 1: reset held low for three cycles.
    tick();
    repeat (3) tick();
    @(negedge clk);
    check("rst_req_valid", XLEN'(mem_req_valid), '0);
    check("rst_dec_valid", XLEN'(dec_valid), '0);
    check("rst_dec_inst", XLEN'(dec_inst), XLEN'(NOP));
    check("rst_dec_pc", dec_pc, '0);
    tick();

    // 2: streaming with an always-ready decoder.
    rst_n = 1'b1;
    dec_ready = 1'b1;
    load_exp(64'h8000_0000);
    mon_en = 1'b1;
    req_cyc = -1;
    dec_cyc = -1;
    bubbles = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (req_cyc < 0 && mem_req_valid && mem_req_ready) begin
        req_cyc = cyc;
        check("first_req_addr", mem_req_addr, 64'h8000_0000);
      end
      if (dec_cyc < 0 && dec_valid) dec_cyc = cyc;
      else if (dec_cyc >= 0 && (cyc - dec_cyc) < 12 && !dec_valid) bubbles++;
      tick();
    end
    check("first_dec_latency", XLEN'(dec_cyc - req_cyc), XLEN'(LAT));
    check("stream_bubbles", XLEN'(bubbles), '0);

    // 3: decode stall fills the buffer, then fetch stops.
    dec_ready = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("stall_req_valid", XLEN'(mem_req_valid), '0);
    check("stall_dec_valid", XLEN'(dec_valid), 64'd1);
    tick();
    mem_hold = 1'b1;
    dec_ready = 1'b1;
    hs0 = n_hs;
    repeat (5) tick();
    check("stall_buffered", XLEN'(n_hs - hs0), XLEN'(DEPTH));
    mem_hold = 1'b0;
    repeat (8) tick();

    // 4: redirect with two requests outstanding.
    mem_hold = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("pre_redir_req_valid", XLEN'(mem_req_valid), '0);
    check("pre_redir_dec_valid", XLEN'(dec_valid), '0);
    tick();
    do_redirect(64'h8000_1002, 64'h8000_1000);
    mem_hold = 1'b0;
    wait_req("redir_addr0", 64'h8000_1000, 6);
    wait_req("redir_addr1", 64'h8000_1004, 3);
    repeat (12) tick();
    check("redir_progress", XLEN'((64 - exp_q.size()) >= 8), 64'd1);

    // 5: redirect collides with a response.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    load_exp(64'h8000_2000);
    @(negedge clk);
    check("collide_resp_present", XLEN'(mem_resp_valid), 64'd1);
    check("collide_no_req", XLEN'(mem_req_valid), '0);
    tick();
    redirect_valid = 1'b0;
    wait_req("collide_next_addr", 64'h8000_2000, 1);
    repeat (10) tick();
    check("collide_progress", XLEN'((64 - exp_q.size()) >= 6), 64'd1);

    // 6: table of redirect targets, including alignment and wrap.
    for (int v = 0; v < 5; v++) begin
      do_redirect(vecs[v].rpc, vecs[v].a0);
      wait_req($sformatf("vec%0d_addr0", v), vecs[v].a0, 4);
      wait_req($sformatf("vec%0d_addr1", v), vecs[v].a1, 3);
      repeat (10) tick();
      check($sformatf("vec%0d_progress", v), XLEN'((64 - exp_q.size()) >= 6), 64'd1);
    end

    // Random ready/hold pressure on an uninterrupted stream.
    do_redirect(64'h9000_0000, 64'h9000_0000);
    exp_q.delete();
    for (int i = 0; i < 220; i++) exp_q.push_back(64'h9000_0000 + XLEN'(4 * i));
    for (int i = 0; i < 180; i++) begin
      dec_ready     = 1'($urandom_range(0, 3) != 0);
      mem_req_ready = 1'($urandom_range(0, 3) != 0);
      mem_hold      = ($urandom_range(0, 4) == 0);
      tick();
    end
    dec_ready = 1'b1;
    mem_req_ready = 1'b1;
    mem_hold = 1'b0;
    repeat (6) tick();
    check("random_progress", XLEN'((220 - exp_q.size()) >= 40), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
